// File: rtl/multdiv_sequencer_pkg.sv
// Shared encodings for the mul/div sequencer and the ALU exception logic.
package multdiv_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdState_e;

    localparam logic [4:0]  RSTATUS_REG     = 5'd30;
    localparam logic [31:0] MUL_STATUS_CODE = 32'd4;
    localparam logic [31:0] DIV_STATUS_CODE = 32'd5;

    typedef struct packed {
        logic        isDiv;
        logic [4:0]  rd;
        logic [31:0] opA;
        logic [31:0] opB;
    } mdReq_t;

    typedef struct packed {
        logic        keep;
        logic [4:0]  wbReg;
        logic [31:0] wbData;
    } mdWb_t;

endpackage

// File: rtl/multdiv_sequencer_timeout_counter.sv
// 6-bit saturating busy-cycle counter; terminal flags the last allowed BUSY cycle.
module md_timeout_counter #(
    parameter int TIMEOUT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);
    localparam logic [5:0] LAST = 6'(TIMEOUT - 1);

    logic [5:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (enable && count != 6'd63)
            count <= count + 6'd1;
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/multdiv_sequencer.sv
// DX-side sequencer for the shared iterative mul/div unit: issue, stall, writeback or abort.
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int          TIMEOUT    = 40,
    parameter logic [31:0] MUL_STATUS = MUL_STATUS_CODE,
    parameter logic [31:0] DIV_STATUS = DIV_STATUS_CODE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dx_is_mult,
    input  logic        dx_is_div,
    input  logic [31:0] dx_opA,
    input  logic [31:0] dx_opB,
    input  logic [4:0]  dx_rd,
    input  logic        flush,
    input  logic        unit_ready,
    input  logic        unit_exception,
    input  logic [31:0] unit_result,
    output logic        unit_ctrl_mult,
    output logic        unit_ctrl_div,
    output logic [31:0] unit_opA,
    output logic [31:0] unit_opB,
    output logic        md_stall,
    output logic        md_wb_valid,
    output logic [4:0]  md_wb_reg,
    output logic [31:0] md_wb_data,
    output logic        md_busy
);
    mdState_e state, stateNext;
    mdReq_t   reqQ;
    mdWb_t    wbQ;
    logic     issue;
    logic     timeoutHit;
    logic     terminal;

    md_timeout_counter #(.TIMEOUT(TIMEOUT)) uTimeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (issue),
        .enable   (state == BUSY),
        .terminal (terminal)
    );

    assign issue      = (state == IDLE) && (dx_is_mult || dx_is_div) && !flush && !reset;
    assign timeoutHit = (state == BUSY) && terminal;

    always_comb begin
        stateNext      = state;
        unit_ctrl_mult = 1'b0;
        unit_ctrl_div  = 1'b0;
        md_stall       = 1'b0;
        md_busy        = 1'b0;
        md_wb_valid    = 1'b0;
        md_wb_reg      = '0;
        md_wb_data     = '0;
        unique case (state)
            IDLE: begin
                unit_ctrl_mult = issue && dx_is_mult;
                unit_ctrl_div  = issue && dx_is_div;
                md_stall       = issue;
                if (issue) stateNext = BUSY;
            end
            BUSY: begin
                md_stall = 1'b1;
                md_busy  = 1'b1;
                if (flush)                         stateNext = IDLE;
                else if (unit_ready || timeoutHit) stateNext = DONE;
            end
            DONE: begin
                // a flush here squashes the mul/div itself, so its write is dropped
                md_wb_valid = wbQ.keep && !flush;
                md_wb_reg   = wbQ.wbReg;
                md_wb_data  = wbQ.wbData;
                stateNext   = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            reqQ  <= '0;
            wbQ   <= '0;
        end else begin
            state <= stateNext;
            if (issue) begin
                reqQ.isDiv <= dx_is_div;
                reqQ.rd    <= dx_rd;
                reqQ.opA   <= dx_opA;
                reqQ.opB   <= dx_opB;
            end
            // ready wins over a timeout landing in the same cycle
            if (state == BUSY && !flush) begin
                if (unit_ready) begin
                    wbQ.keep   <= unit_exception || (reqQ.rd != 5'd0);
                    wbQ.wbReg  <= unit_exception ? RSTATUS_REG : reqQ.rd;
                    wbQ.wbData <= !unit_exception ? unit_result :
                                  (reqQ.isDiv ? DIV_STATUS : MUL_STATUS);
                end else if (timeoutHit) begin
                    wbQ.keep   <= 1'b1;
                    wbQ.wbReg  <= RSTATUS_REG;
                    wbQ.wbData <= DIV_STATUS;
                end
            end
        end
    end

    assign unit_opA = reqQ.opA;
    assign unit_opB = reqQ.opB;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomized bench for multdiv_sequencer against a timeline model of each operation.
module tb_multdiv_sequencer;
    localparam int TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic        dx_is_mult, dx_is_div;
    logic [31:0] dx_opA, dx_opB;
    logic [4:0]  dx_rd;
    logic        flush;
    logic        unit_ready, unit_exception;
    logic [31:0] unit_result;
    logic        unit_ctrl_mult, unit_ctrl_div;
    logic [31:0] unit_opA, unit_opB;
    logic        md_stall, md_wb_valid, md_busy;
    logic [4:0]  md_wb_reg;
    logic [31:0] md_wb_data;

    int nChecks = 0;
    int nErrors = 0;

    multdiv_sequencer #(.TIMEOUT(TIMEOUT), .MUL_STATUS(32'd4), .DIV_STATUS(32'd5)) dut (
        .clock          (clock),
        .reset          (reset),
        .dx_is_mult     (dx_is_mult),
        .dx_is_div      (dx_is_div),
        .dx_opA         (dx_opA),
        .dx_opB         (dx_opB),
        .dx_rd          (dx_rd),
        .flush          (flush),
        .unit_ready     (unit_ready),
        .unit_exception (unit_exception),
        .unit_result    (unit_result),
        .unit_ctrl_mult (unit_ctrl_mult),
        .unit_ctrl_div  (unit_ctrl_div),
        .unit_opA       (unit_opA),
        .unit_opB       (unit_opB),
        .md_stall       (md_stall),
        .md_wb_valid    (md_wb_valid),
        .md_wb_reg      (md_wb_reg),
        .md_wb_data     (md_wb_data),
        .md_busy        (md_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet(input string tag);
        chk({tag, "_mult"},  unit_ctrl_mult, 0);
        chk({tag, "_div"},   unit_ctrl_div, 0);
        chk({tag, "_stall"}, md_stall, 0);
        chk({tag, "_busy"},  md_busy, 0);
        chk({tag, "_wbv"},   md_wb_valid, 0);
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            tick();
            dx_is_mult = 0; dx_is_div = 0; flush = 0;
            unit_ready = 0; unit_exception = 0; unit_result = $urandom;
            @(negedge clock);
            quiet("idle");
        end
    endtask

    // lat > TIMEOUT means the unit never answers; flushAt counts BUSY cycles from 1,
    // flushAt == n+1 lands on the writeback cycle, 0 means no flush
    task automatic runOp(input logic isDiv, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int lat, input logic uExc, input int flushAt);
        int          n;
        logic [31:0] res, expData;
        logic [4:0]  expReg;
        logic        expExc, expValid, flushedBusy;
        n           = (lat <= TIMEOUT) ? lat : TIMEOUT;
        res         = isDiv ? ((b == 0) ? 32'd0 : a / b) : a * b;
        expExc      = (lat > TIMEOUT) ? 1'b1 : uExc;
        expReg      = expExc ? 5'd30 : rd;
        expData     = !expExc ? res : ((lat > TIMEOUT || isDiv) ? 32'd5 : 32'd4);
        expValid    = expExc || (rd != 0);
        flushedBusy = (flushAt >= 1) && (flushAt <= n);

        tick();
        dx_is_mult = !isDiv; dx_is_div = isDiv; dx_opA = a; dx_opB = b; dx_rd = rd;
        flush = 0; unit_ready = 0; unit_exception = 0;
        @(negedge clock);
        chk("issue_mult",  unit_ctrl_mult, !isDiv);
        chk("issue_div",   unit_ctrl_div, isDiv);
        chk("issue_stall", md_stall, 1);
        chk("issue_busy",  md_busy, 0);

        for (int t = 1; t <= n; t++) begin
            tick();
            flush          = (t == flushAt);
            unit_ready     = (t == lat);
            unit_exception = (t == lat) && uExc;
            unit_result    = (t == lat) ? res : $urandom;
            @(negedge clock);
            chk("busy_busy",  md_busy, 1);
            chk("busy_stall", md_stall, 1);
            chk("busy_mult",  unit_ctrl_mult, 0);
            chk("busy_div",   unit_ctrl_div, 0);
            chk("busy_wbv",   md_wb_valid, 0);
            if (t == 1) begin
                chk("opA", unit_opA, a);
                chk("opB", unit_opB, b);
            end
            if (t == flushAt) break;
        end

        if (flushedBusy) begin
            for (int k = 1; k <= 4; k++) begin
                tick();
                dx_is_mult = 0; dx_is_div = 0; flush = 0;
                unit_ready = (k == 3); unit_exception = 0; unit_result = $urandom;
                @(negedge clock);
                quiet("abort");
            end
        end else begin
            tick();
            flush = (flushAt == n + 1);
            unit_ready = 1'($urandom_range(0, 1)); unit_exception = 0; unit_result = $urandom;
            @(negedge clock);
            chk("done_mult",  unit_ctrl_mult, 0);
            chk("done_div",   unit_ctrl_div, 0);
            chk("done_stall", md_stall, 0);
            chk("done_busy",  md_busy, 0);
            chk("done_wbv",   md_wb_valid, expValid && !flush);
            if (expValid && !flush) begin
                chk("done_reg",  md_wb_reg, expReg);
                chk("done_data", md_wb_data, expData);
            end
        end
    endtask

    initial begin
        reset = 1; dx_is_mult = 0; dx_is_div = 0; dx_opA = 0; dx_opB = 0; dx_rd = 0;
        flush = 0; unit_ready = 0; unit_exception = 0; unit_result = 0;
        tick(); tick();
        @(negedge clock);
        quiet("rst");
        chk("rst_opA", unit_opA, 0);
        chk("rst_reg", md_wb_reg, 0);
        chk("rst_data", md_wb_data, 0);
        tick(); reset = 0;
        idle(2);

        runOp(0, 7, 6, 3, 16, 0, 0);              // basic multiply
        idle(1);
        runOp(1, 100, 0, 9, 33, 1, 0);            // divide by zero
        idle(1);
        runOp(0, 5, 5, 4, 999, 0, 0);             // timeout
        idle(1);
        runOp(0, 3, 4, 7, 20, 0, 5);              // flush in BUSY, late ready
        runOp(0, 11, 13, 8, 3, 0, 0);             // back-to-back
        runOp(0, 2, 9, 12, 4, 0, 0);
        idle(1);
        runOp(1, 50, 7, 2, 4, 0, 5);              // flush on writeback cycle
        idle(1);
        runOp(0, 32'h8000_0000, 4, 6, TIMEOUT, 1, 0); // ready on the last allowed cycle
        idle(1);

        // reset in the middle of BUSY
        tick();
        dx_is_mult = 1; dx_opA = 9; dx_opB = 9; dx_rd = 5;
        for (int k = 0; k < 3; k++) tick();
        reset = 1; dx_is_mult = 0;
        tick();
        reset = 0;
        @(negedge clock);
        quiet("midrst");
        chk("midrst_opA", unit_opA, 0);
        chk("midrst_opB", unit_opB, 0);
        chk("midrst_reg", md_wb_reg, 0);

        runOp(0, 2, 3, 0, 5, 0, 0);               // rd = 0 drops the write
        idle(1);

        for (int i = 0; i < 40; i++) begin
            logic        isDiv, uExc;
            logic [31:0] a, b;
            logic [4:0]  rd;
            int          lat, n, fl;
            isDiv = 1'($urandom_range(0, 1));
            a     = $urandom;
            b     = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            lat   = $urandom_range(1, TIMEOUT + 5);
            uExc  = isDiv ? (b == 0) : ($urandom_range(0, 7) == 0);
            n     = (lat <= TIMEOUT) ? lat : TIMEOUT;
            fl    = ($urandom_range(0, 4) == 0) ? $urandom_range(1, n + 1) : 0;
            runOp(isDiv, a, b, rd, lat, uExc, fl);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
